// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit datapath.
// Owns the PC and instruction register; datapath field outputs decode directly from IR.
module instr_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic [3:0]      rf_raddr1,
    output logic [3:0]      rf_raddr2,
    output logic [3:0]      rf_waddr,
    output logic            rf_we,
    output logic [3:0]      alu_op,
    output logic            alu_sel_imm,
    output logic [3:0]      imm,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [15:0]     ir;
    logic [3:0]      ir_op;
    logic            op_imm;
    logic            op_writes;
    logic            op_illegal;
    logic            op_halt;

    always_comb begin
        ir_op      = ir[15:12];
        op_imm     = (ir_op >= 4'd5) && (ir_op <= 4'd8);
        op_writes  = (ir_op <= 4'd8);
        op_illegal = (ir_op >= 4'd9) && (ir_op <= 4'd14);
        op_halt    = (ir_op == 4'd15);
        pc_inc     = pc + PC_W'(1);
    end

    // IR only changes on a FETCH->DECODE transition, so these hold outside DECODE..WB.
    always_comb begin
        rf_raddr1   = ir[11:8];
        rf_raddr2   = ir[7:4];
        rf_waddr    = op_imm ? ir[7:4] : ir[3:0];
        alu_op      = ir_op;
        alu_sel_imm = op_imm;
        imm         = ir[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            rf_we     <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            rf_we   <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    pc <= RESET_PC;
                    if (run) begin
                        state     <= S_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= RESET_PC;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    illegal <= op_illegal;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_halt) begin
                        state   <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        retired <= retired + 16'd1;
                    end else begin
                        state <= S_WB;
                        rf_we <= op_writes;
                    end
                end
                S_WB: begin
                    pc        <= pc_inc;
                    retired   <= retired + 16'd1;
                    state     <= S_FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_inc;
                end
                S_HALT: begin
                    if (run) begin
                        pc        <= RESET_PC;
                        halted    <= 1'b0;
                        state     <= S_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= RESET_PC;
                        busy      <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs plus random programs/wait states,
// checked against an instruction-level model of fetch addresses, writes and retire counts.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        use_b;

    // Instance A: 8-bit PC
    logic        req_a, we_a, alu_sel_a, busy_a, halted_a, illegal_a;
    logic [7:0]  addr_a;
    logic [3:0]  ra1_a, ra2_a, wa_a, op_a, imm_a;
    logic [15:0] ret_a;
    // Instance B: 2-bit PC to exercise wrap
    logic        req_b, we_b, alu_sel_b, busy_b, halted_b, illegal_b;
    logic [1:0]  addr_b;
    logic [3:0]  ra1_b, ra2_b, wa_b, op_b, imm_b;
    logic [15:0] ret_b;

    logic run_a, run_b, valid_a, valid_b;
    assign run_a   = run & ~use_b;
    assign run_b   = run & use_b;
    assign valid_a = imem_valid & ~use_b;
    assign valid_b = imem_valid & use_b;

    instr_sequencer #(.PC_W(8), .RESET_PC(8'd0)) dut_a (
        .clk(clk), .rst(rst), .run(run_a),
        .imem_req(req_a), .imem_addr(addr_a), .imem_valid(valid_a), .imem_data(imem_data),
        .rf_raddr1(ra1_a), .rf_raddr2(ra2_a), .rf_waddr(wa_a), .rf_we(we_a),
        .alu_op(op_a), .alu_sel_imm(alu_sel_a), .imm(imm_a),
        .busy(busy_a), .halted(halted_a), .illegal(illegal_a), .retired(ret_a)
    );

    instr_sequencer #(.PC_W(2), .RESET_PC(2'd0)) dut_b (
        .clk(clk), .rst(rst), .run(run_b),
        .imem_req(req_b), .imem_addr(addr_b), .imem_valid(valid_b), .imem_data(imem_data),
        .rf_raddr1(ra1_b), .rf_raddr2(ra2_b), .rf_waddr(wa_b), .rf_we(we_b),
        .alu_op(op_b), .alu_sel_imm(alu_sel_b), .imm(imm_b),
        .busy(busy_b), .halted(halted_b), .illegal(illegal_b), .retired(ret_b)
    );

    // Observed view of whichever instance is under test
    logic        o_req, o_we, o_sel, o_busy, o_halted, o_illegal;
    logic [7:0]  o_addr;
    logic [3:0]  o_ra1, o_ra2, o_wa, o_op, o_imm;
    logic [15:0] o_ret;
    assign o_req     = use_b ? req_b : req_a;
    assign o_we      = use_b ? we_b : we_a;
    assign o_sel     = use_b ? alu_sel_b : alu_sel_a;
    assign o_busy    = use_b ? busy_b : busy_a;
    assign o_halted  = use_b ? halted_b : halted_a;
    assign o_illegal = use_b ? illegal_b : illegal_a;
    assign o_addr    = use_b ? {6'd0, addr_b} : addr_a;
    assign o_ra1     = use_b ? ra1_b : ra1_a;
    assign o_ra2     = use_b ? ra2_b : ra2_a;
    assign o_wa      = use_b ? wa_b : wa_a;
    assign o_op      = use_b ? op_b : op_a;
    assign o_imm     = use_b ? imm_b : imm_a;
    assign o_ret     = use_b ? ret_b : ret_a;

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    logic [7:0]  m_pc;
    logic [7:0]  m_mask;
    logic [15:0] m_ret;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE/HALT and step instruction by instruction until HALT or max_instr.
    task automatic run_prog(input int unsigned max_instr, input int unsigned wmin,
                            input int unsigned wmax, input bit run_in_exec);
        logic [15:0] word;
        logic [3:0]  op;
        bit          imm_form;
        bit          writes;
        int unsigned w;
        // a valid coincident with the start pulse must not be taken
        run = 1'b1; imem_valid = 1'b1; imem_data = 16'h0123;
        tick();
        run = 1'b0; imem_valid = 1'b0;
        m_pc = 8'd0;
        check("start_halted", o_halted, 0);
        for (int unsigned k = 0; k < max_instr; k++) begin
            w = $urandom_range(wmax, wmin);
            for (int unsigned c = 0; c <= w; c++) begin
                check("fetch_req", o_req, 1);
                check("fetch_addr", o_addr, m_pc);
                check("fetch_we", o_we, 0);
                check("fetch_busy", o_busy, 1);
                if (c == w) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[o_addr];
                end
                tick();
                imem_valid = 1'b0;
            end
            word     = mem[m_pc];
            op       = word[15:12];
            imm_form = (op >= 4'd5) && (op <= 4'd8);
            writes   = (op <= 4'd8);
            // DECODE
            check("dec_req", o_req, 0);
            check("dec_busy", o_busy, 1);
            check("dec_raddr1", o_ra1, word[11:8]);
            check("dec_raddr2", o_ra2, word[7:4]);
            check("dec_op", o_op, op);
            check("dec_imm", o_imm, word[3:0]);
            check("dec_sel", o_sel, imm_form);
            check("dec_we", o_we, 0);
            check("dec_illegal", o_illegal, 0);
            if (run_in_exec) run = 1'b1;
            tick();
            // EXEC
            check("exec_illegal", o_illegal, (op >= 4'd9) && (op <= 4'd14));
            check("exec_we", o_we, 0);
            check("exec_op", o_op, op);
            tick();
            run = 1'b0;
            if (op == 4'd15) begin
                m_ret++;
                check("halt_halted", o_halted, 1);
                check("halt_busy", o_busy, 0);
                check("halt_req", o_req, 0);
                check("halt_retired", o_ret, m_ret);
                check("halt_illegal", o_illegal, 0);
                return;
            end
            // WB
            check("wb_we", o_we, writes);
            if (writes) check("wb_waddr", o_wa, imm_form ? word[7:4] : word[3:0]);
            check("wb_illegal", o_illegal, 0);
            check("wb_retired", o_ret, m_ret);
            tick();
            m_ret++;
            m_pc = (m_pc + 8'd1) & m_mask;
            check("next_retired", o_ret, m_ret);
            check("next_we", o_we, 0);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; imem_valid = 1'b0; imem_data = '0; use_b = 1'b0;
        m_mask = 8'hFF; m_ret = '0; m_pc = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        tick(); tick();
        check("rst_req", o_req, 0);
        check("rst_addr", o_addr, 0);
        check("rst_we", o_we, 0);
        check("rst_busy", o_busy, 0);
        check("rst_halted", o_halted, 0);
        check("rst_illegal", o_illegal, 0);
        check("rst_retired", o_ret, 0);
        check("rst_fields", {o_ra1, o_ra2, o_wa, o_op, o_imm, 3'b000, o_sel}, 0);
        rst = 1'b0;
        tick();
        check("idle_req", o_req, 0);

        // Directed zero-wait program
        mem[0] = 16'h1234; mem[1] = 16'h5A73; mem[2] = 16'hF000;
        run_prog(10, 0, 0, 1'b0);
        check("p1_addr", o_addr, 2);
        check("p1_retired", o_ret, 3);

        // Three wait states, with an illegal opcode before the halt
        for (int i = 0; i < 4; i++) mem[i] = {4'($urandom_range(8, 0)), 12'($urandom)};
        mem[4] = 16'h9ABC; mem[5] = 16'hF000;
        run_prog(10, 3, 3, 1'b0);
        check("p2_addr", o_addr, 5);

        // Random program with random waits, run pulsed during DECODE/EXEC
        for (int i = 0; i < 24; i++) mem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
        mem[24] = 16'hF123;
        run_prog(30, 0, 3, 1'b1);
        check("p3_retired", o_ret, m_ret);

        // Reset in the middle of a fetch wait; late valid must be ignored
        mem[0] = 16'h1234; mem[1] = 16'hF000;
        run = 1'b1; tick(); run = 1'b0;
        tick();
        check("midf_req", o_req, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midf_rst_req", o_req, 0);
        imem_valid = 1'b1; imem_data = mem[0];
        tick();
        imem_valid = 1'b0;
        check("midf_late_req", o_req, 0);
        check("midf_late_busy", o_busy, 0);
        check("midf_late_op", o_op, 0);
        check("midf_late_ret", o_ret, 0);
        tick();
        check("midf_idle_req", o_req, 0);
        m_ret = '0;
        run_prog(10, 0, 2, 1'b0);
        check("midf_retired", o_ret, 2);

        // 2-bit PC wraps: four register-form instructions, no HALT
        use_b = 1'b1; m_mask = 8'h03; m_ret = '0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check("b_rst_ret", o_ret, 0);
        for (int i = 0; i < 4; i++) mem[i] = {4'h0, 12'($urandom)};
        tick();
        run_prog(5, 0, 1, 1'b0);
        check("b_retired", o_ret, 5);
        check("b_addr_wrapped", o_addr, 1);
        rst = 1'b1; tick(); rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
